// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared state type and CRC_A verdict constants for the rx frame checker
package rx_frame_pkg;
  typedef enum logic [1:0] {IDLE, RX, WAIT, DONE} rx_frame_state_t;
  localparam logic [15:0] CRC_A_RESIDUE = 16'h0000;
  localparam int MIN_CRC_FRAME_BYTES = 3;
endpackage

// File: rtl/bit_byte_counter.sv
// bit_byte_counter: 3-bit bit counter with saturating byte counter and overflow flag
module bit_byte_counter #(
  parameter int MAX_BYTES = 64,
  parameter int BW = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [2:0]    bit_count,
  output logic [BW-1:0] byte_count,
  output logic          overflow
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      bit_count  <= '0;
      byte_count <= '0;
      overflow   <= 1'b0;
    end else if (inc) begin
      bit_count <= bit_count + 3'd1;
      if (bit_count == 3'd7) begin
        if (byte_count == BW'(MAX_BYTES)) overflow <= 1'b1;
        else byte_count <= byte_count + BW'(1);
      end
    end
  end
endmodule

// File: rtl/rx_frame_crc_check.sv
// rx_frame_crc_check: feeds crc_a from the rx bit stream and issues an end-of-frame verdict
module rx_frame_crc_check
  import rx_frame_pkg::*;
#(
  parameter int MAX_BYTES = 64,
  localparam int BW = $clog2(MAX_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soc,
  input  logic          eoc,
  input  logic          data,
  input  logic          data_valid,
  input  logic          error,
  output logic          crc_start,
  output logic          crc_data,
  output logic          crc_sample,
  input  logic [15:0]   crc,
  output logic          frame_done,
  output logic          crc_ok,
  output logic [BW-1:0] byte_count,
  output logic [2:0]    bit_count,
  output logic          rx_error,
  output logic          overflow
);
  rx_frame_state_t state, state_next;
  assign crc_start  = soc;
  assign crc_data   = data;
  assign crc_sample = data_valid && state == RX && !soc;
  // a soc landing in DONE abandons that frame, so its strobe is suppressed
  assign frame_done = state == DONE && !soc;
  bit_byte_counter #(.MAX_BYTES(MAX_BYTES), .BW(BW)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clear(soc),
    .inc(crc_sample),
    .bit_count(bit_count),
    .byte_count(byte_count),
    .overflow(overflow)
  );
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_next;
  end
  always_comb begin
    state_next = state;
    state_next = soc ? RX
               : state == RX ? (error ? DONE : eoc ? WAIT : RX)
               : state == WAIT ? DONE
               : IDLE;
  end
  // crc settles during WAIT, so the verdict is latched there and visible in DONE
  always_ff @(posedge clk) begin
    if (rst || soc) begin
      crc_ok   <= 1'b0;
      rx_error <= 1'b0;
    end else if (state == RX && error) begin
      rx_error <= 1'b1;
    end else if (state == WAIT) begin
      crc_ok <= crc == CRC_A_RESIDUE && bit_count == 3'd0 &&
                byte_count >= BW'(MIN_CRC_FRAME_BYTES) && !overflow && !rx_error;
    end
  end
endmodule
